// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
//
// Shared definitions for the internal 12-bit bus and its two-port arbiter.
//
// Contents:
//   BUS_D_WIDTH  - native width of the shared internal bus.
//   PORT_FETCH   - owner ID of port 0 (instruction fetch path).
//   PORT_DATA    - owner ID of port 1 (load/store data path).
//   bus_state_t  - arbiter ownership state: IDLE / OWN0 / OWN1.
// -----------------------------------------------------------------------------
package bus_pkg;

   localparam int BUS_D_WIDTH = 12;

   // Owner IDs as they appear on bus_owner.
   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   // Ownership state. 2'b11 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } bus_state_t;

endpackage : bus_pkg

// File: rtl/mux2.sv
// -----------------------------------------------------------------------------
// mux2
//
// Two-way word multiplexer used as the shared bus datapath.
//
// Parameters:
//   d_width   - data word width.
//   sel_width - select width; any non-zero select picks mux2_data1.
//
// Ports:
//   mux2_sel    in   select (0 -> mux2_data0, otherwise mux2_data1)
//   mux2_data0  in   word for select 0
//   mux2_data1  in   word for select 1
//   mux2_result out  selected word (purely combinational)
// -----------------------------------------------------------------------------
module mux2 #(
   parameter int d_width   = 12,
   parameter int sel_width = 1
) (
   input  logic [sel_width-1:0] mux2_sel,
   input  logic [d_width-1:0]   mux2_data0,
   input  logic [d_width-1:0]   mux2_data1,
   output logic [d_width-1:0]   mux2_result
);

   always_comb begin
      mux2_result = mux2_data0;
      if (mux2_sel != '0) begin
         mux2_result = mux2_data1;
      end
   end

endmodule : mux2

// File: rtl/bus_arb2.sv
// -----------------------------------------------------------------------------
// bus_arb2
//
// Two-requester arbiter and sequencer for the shared internal bus. Port 0 is
// the fetch path, port 1 the data path. Ownership is decided every cycle and
// held in a registered state; a registered select steers the shared mux2 so
// only the owner's word reaches the bus. A hold counter bounds how long one
// port may keep the bus while the other waits, and a last-served register
// breaks ties from IDLE in round-robin order.
//
// Handshake: reqN is a level request. A request high at rising edge N gives
// gntN high after edge N when the bus is free; the requester keeps reqN high
// and dataN stable for as long as it needs the bus, and drops reqN to release
// it. gntN falls at the first edge that samples reqN low, or when the other
// port is waiting and this port has already held the bus MAX_HOLD cycles.
//
// Parameters:
//   D_WIDTH   - bus data width.
//   MAX_HOLD  - max consecutive grant cycles while the other port waits (1..15).
//   CNT_WIDTH - hold counter width, 2**CNT_WIDTH > MAX_HOLD.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req0/req1  in   port requests (level, held while ownership is needed)
//   data0/1    in   port words
//   gnt0/gnt1  out  registered grants, never both high
//   bus_valid  out  gnt0 | gnt1
//   bus_owner  out  registered select, 0 = port 0, 1 = port 1
//   bus_data   out  owner's word, combinational from bus_owner and data inputs
//   dbg_state  out  current arbiter state
//   dbg_hold   out  current hold count
// -----------------------------------------------------------------------------
module bus_arb2
   import bus_pkg::*;
#(
   parameter int D_WIDTH   = BUS_D_WIDTH,
   parameter int MAX_HOLD  = 8,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [D_WIDTH-1:0]   data0,
   input  logic [D_WIDTH-1:0]   data1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 bus_valid,
   output logic                 bus_owner,
   output logic [D_WIDTH-1:0]   bus_data,
   output bus_state_t           dbg_state,
   output logic [CNT_WIDTH-1:0] dbg_hold
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
      $error("bus_arb2: MAX_HOLD must be in 1..15");
   end
   if ((1 << CNT_WIDTH) <= MAX_HOLD) begin : g_bad_cnt_width
      $error("bus_arb2: CNT_WIDTH too narrow for MAX_HOLD");
   end

   // Last hold value before a waiting port forces a switch.
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   bus_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] hold_q,  hold_d;
   logic                 last_q,  last_d;
   logic                 owner_q, owner_d;

   logic                 hold_at_last;

   assign hold_at_last = (hold_q == HOLD_LAST);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      owner_d = owner_q;

      unique case (state_q)
         IDLE: begin
            // On a tie the port that was not served most recently wins.
            if (req0 && !(req1 && (last_q == PORT_FETCH))) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end
         end

         OWN0: begin
            if (req0 && !(req1 && hold_at_last)) begin
               // Saturate so a long solo grant still switches promptly once
               // the other port starts waiting.
               if (!hold_at_last) begin
                  hold_d = hold_q + CNT_WIDTH'(1);
               end
            end else if (req1) begin
               state_d = OWN1;
            end else begin
               state_d = IDLE;
            end
         end

         OWN1: begin
            if (req1 && !(req0 && hold_at_last)) begin
               if (!hold_at_last) begin
                  hold_d = hold_q + CNT_WIDTH'(1);
               end
            end else if (req0) begin
               state_d = OWN0;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Any entry into an ownership state restarts the hold count and
      // records the new owner. Staying in the same state is not an entry.
      if (state_d != state_q) begin
         if (state_d == OWN0) begin
            hold_d  = '0;
            last_d  = PORT_FETCH;
            owner_d = PORT_FETCH;
         end else if (state_d == OWN1) begin
            hold_d  = '0;
            last_d  = PORT_DATA;
            owner_d = PORT_DATA;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         last_q  <= PORT_DATA;   // so port 0 wins the first tie
         owner_q <= PORT_FETCH;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: grants decode directly from the state register.
   // ---------------------------------------------------------------------------
   assign gnt0      = (state_q == OWN0);
   assign gnt1      = (state_q == OWN1);
   assign bus_valid = gnt0 | gnt1;
   assign bus_owner = owner_q;
   assign dbg_state = state_q;
   assign dbg_hold  = hold_q;

   // Shared datapath; bus_owner keeps its value in IDLE, so bus_data keeps
   // following the last owner while bus_valid is low.
   mux2 #(
      .d_width   (D_WIDTH),
      .sel_width (1)
   ) u_mux2 (
      .mux2_sel    (owner_q),
      .mux2_data0  (data0),
      .mux2_data1  (data1),
      .mux2_result (bus_data)
   );

endmodule : bus_arb2

// File: tb/tb_bus_arb2.sv
// -----------------------------------------------------------------------------
// tb_bus_arb2
//
// Self-checking bench for bus_arb2. u_dut uses MAX_HOLD=8; u_dut1 uses
// MAX_HOLD=1 on the same inputs. Each cycle a scenario task drives inputs,
// pushes the expected {gnt0, gnt1, bus_valid, bus_owner, bus_data} word,
// clocks once and compares the DUT against the popped expectation.
// -----------------------------------------------------------------------------
module tb_bus_arb2;
   import bus_pkg::*;

   localparam int W  = 12;
   localparam int EW = W + 4;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT signals
   // ---------------------------------------------------------------------------
   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0  = 1'b0;
   logic          req1  = 1'b0;
   logic [W-1:0]  data0 = '0;
   logic [W-1:0]  data1 = '0;

   logic          gnt0, gnt1, bus_valid, bus_owner;
   logic [W-1:0]  bus_data;
   bus_state_t    dbg_state;
   logic [3:0]    dbg_hold;

   logic          a_gnt0, a_gnt1, a_bus_valid, a_bus_owner;
   logic [W-1:0]  a_bus_data;
   bus_state_t    a_dbg_state;
   logic [0:0]    a_dbg_hold;

   always #5 clk = ~clk;

   bus_arb2 #(.D_WIDTH(W), .MAX_HOLD(8), .CNT_WIDTH(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .bus_valid (bus_valid),
      .bus_owner (bus_owner),
      .bus_data  (bus_data),
      .dbg_state (dbg_state),
      .dbg_hold  (dbg_hold)
   );

   bus_arb2 #(.D_WIDTH(W), .MAX_HOLD(1), .CNT_WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
      .gnt0      (a_gnt0),
      .gnt1      (a_gnt1),
      .bus_valid (a_bus_valid),
      .bus_owner (a_bus_owner),
      .bus_data  (a_bus_data),
      .dbg_state (a_dbg_state),
      .dbg_hold  (a_dbg_hold)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   // Expected output word from expected grants/owner and the current data.
   function automatic logic [EW-1:0] exp_word(input logic g0, input logic g1,
                                              input logic own);
      return {g0, g1, g0 | g1, own, (own ? data1 : data0)};
   endfunction

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic a, input logic b);
      rst_n = r;
      req0  = a;
      req1  = b;
      data0 = W'($urandom_range(0, 4095));
      data1 = W'($urandom_range(0, 4095));
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [EW-1:0] got, exp;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0, 1: begin drive(1'b0, 1'b1, 1'b1); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0)); end
            2:    begin drive(1'b1, 1'b1, 1'b1); exp_q.push_back(exp_word(1'b1, 1'b0, 1'b0)); end
            default: begin drive(1'b1, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0)); end
         endcase
         tick();
         got = {gnt0, gnt1, bus_valid, bus_owner, bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL reset cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_single();
      logic [EW-1:0] got, exp;
      for (int i = 0; i < 21; i++) begin
         if (i < 20) begin
            drive(1'b1, 1'b0, 1'b1);
            data1 = 12'hA5C;
            exp_q.push_back(exp_word(1'b0, 1'b1, 1'b1));
         end else begin
            drive(1'b1, 1'b0, 1'b0);
            data1 = 12'hA5C;
            exp_q.push_back(exp_word(1'b0, 1'b0, 1'b1));
         end
         tick();
         got = {gnt0, gnt1, bus_valid, bus_owner, bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL single cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_contention();
      logic [EW-1:0] got, exp;
      logic          own;
      for (int i = 0; i < 41; i++) begin
         if (i < 40) begin
            own = 1'((i / 8) % 2);
            drive(1'b1, 1'b1, 1'b1);
            exp_q.push_back(exp_word(own == 1'b0, own == 1'b1, own));
         end else begin
            drive(1'b1, 1'b0, 1'b0);
            exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0));
         end
         tick();
         got = {gnt0, gnt1, bus_valid, bus_owner, bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL contention cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_early_release();
      logic [EW-1:0] got, exp;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            drive(1'b1, 1'b1, 1'b0); exp_q.push_back(exp_word(1'b1, 1'b0, 1'b0));
         end else if (i < 4) begin
            drive(1'b1, 1'b1, 1'b1); exp_q.push_back(exp_word(1'b1, 1'b0, 1'b0));
         end else if (i < 7) begin
            drive(1'b1, 1'b0, 1'b1); exp_q.push_back(exp_word(1'b0, 1'b1, 1'b1));
         end else begin
            drive(1'b1, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b1));
         end
         tick();
         got = {gnt0, gnt1, bus_valid, bus_owner, bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL early_release cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_mid_reset();
      logic [EW-1:0] got, exp;
      for (int i = 0; i < 9; i++) begin
         if (i < 6) begin
            drive(1'b1, 1'b0, 1'b1); exp_q.push_back(exp_word(1'b0, 1'b1, 1'b1));
         end else if (i == 6) begin
            drive(1'b0, 1'b1, 1'b1); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0));
         end else if (i == 7) begin
            drive(1'b1, 1'b1, 1'b1); exp_q.push_back(exp_word(1'b1, 1'b0, 1'b0));
         end else begin
            drive(1'b1, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0));
         end
         tick();
         got = {gnt0, gnt1, bus_valid, bus_owner, bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL mid_reset cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_rr_tie();
      logic [EW-1:0] got, exp;
      for (int i = 0; i < 6; i++) begin
         if (i < 2) begin
            drive(1'b1, 1'b1, 1'b0); exp_q.push_back(exp_word(1'b1, 1'b0, 1'b0));
         end else if (i == 2) begin
            drive(1'b1, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0));
         end else if (i < 5) begin
            drive(1'b1, 1'b1, 1'b1); exp_q.push_back(exp_word(1'b0, 1'b1, 1'b1));
         end else begin
            drive(1'b1, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b1));
         end
         tick();
         got = {gnt0, gnt1, bus_valid, bus_owner, bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL rr_tie cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   // Long solo grant saturates hold, so a newly waiting port gets the bus at
   // the very next edge; then the normal 8/8 alternation resumes.
   task automatic test_hold_saturate();
      logic [EW-1:0] got, exp;
      logic          own;
      for (int i = 0; i < 23; i++) begin
         if (i < 12) begin
            drive(1'b1, 1'b1, 1'b0); exp_q.push_back(exp_word(1'b1, 1'b0, 1'b0));
         end else if (i < 22) begin
            own = (i - 12) < 8;
            drive(1'b1, 1'b1, 1'b1);
            exp_q.push_back(exp_word(own == 1'b0, own == 1'b1, own));
         end else begin
            drive(1'b1, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0));
         end
         tick();
         got = {gnt0, gnt1, bus_valid, bus_owner, bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL hold_saturate cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   // MAX_HOLD=1 instance: strict per-cycle alternation under contention.
   task automatic test_strict_alt();
      logic [EW-1:0] got, exp;
      logic          own;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) begin
            drive(1'b0, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b0));
         end else if (i < 9) begin
            own = 1'((i - 1) % 2);
            drive(1'b1, 1'b1, 1'b1);
            exp_q.push_back(exp_word(own == 1'b0, own == 1'b1, own));
         end else begin
            drive(1'b1, 1'b0, 1'b0); exp_q.push_back(exp_word(1'b0, 1'b0, 1'b1));
         end
         tick();
         got = {a_gnt0, a_gnt1, a_bus_valid, a_bus_owner, a_bus_data};
         exp = exp_q.pop_front();
         if (got !== exp) $display("FAIL strict_alt cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         n_checks++;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_single();
      test_contention();
      test_early_release();
      test_mid_reset();
      test_rr_tie();
      test_hold_saturate();
      test_strict_alt();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
      $fatal(1, "watchdog");
   end

endmodule : tb_bus_arb2
